// File: rtl/ram_arb_pkg.sv
// Shared constants and encodings for the 64x32 RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned RAM_ADDR_W = 6;
    localparam int unsigned RAM_DATA_W = 32;
    localparam int unsigned RAM_DEPTH  = 64;

    typedef enum logic {
        CLEAR,
        RUN
    } arb_state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/ram_64x32_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two request/grant/read-return channels (A and B).
interface ram_64x32_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
);

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata
    );

endinterface

// File: rtl/ram_64x32_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; prio selects the winner only under contention.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic prio,
    output logic gnt_a,
    output logic gnt_b
);

    always_comb begin
        gnt_a = req_a && (!req_b || prio == OWN_A);
        gnt_b = req_b && (!req_a || prio == OWN_B);
    end

endmodule

// File: rtl/ram_64x32_arbiter.sv
// Round-robin arbiter/sequencer for a single-port 64x32 synchronous RAM.
// Define RAM_ARB_CLEAR_EN to zero all RAM words after reset before serving requests.
module ram_64x32_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    ram_64x32_arbiter_if.slave   bus,
    output logic                 busy,
    output logic                 Mem_Write,
    output logic [ADDR_W-1:0]    Mem_Addr,
    output logic [DATA_W-1:0]    M_W_Data,
    input  logic [DATA_W-1:0]    M_R_Data
);

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH must equal 2**ADDR_W");
    end

    arb_state_t        state;
    logic              prio;
    logic              run_en;
    logic              gnt_a;
    logic              gnt_b;
    logic              rd_issued;
    logic              rd_owner;
    logic              a_rvalid;
    logic              b_rvalid;
    logic [DATA_W-1:0] a_hold;
    logic [DATA_W-1:0] b_hold;

`ifdef RAM_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        state = RUN;
        busy  = 1'b0;
    end
`endif

    assign run_en = rst_n && (state == RUN);

    rr_arb2 u_rr_arb2 (
        .req_a (bus.a_req && run_en),
        .req_b (bus.b_req && run_en),
        .prio  (prio),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign bus.a_gnt = gnt_a;
    assign bus.b_gnt = gnt_b;

    always_comb begin
        Mem_Write = 1'b0;
        Mem_Addr  = '0;
        M_W_Data  = '0;
        if (gnt_a) begin
            Mem_Write = bus.a_we;
            Mem_Addr  = bus.a_addr;
            M_W_Data  = bus.a_wdata;
        end else if (gnt_b) begin
            Mem_Write = bus.b_we;
            Mem_Addr  = bus.b_addr;
            M_W_Data  = bus.b_wdata;
        end
`ifdef RAM_ARB_CLEAR_EN
        if (state == CLEAR) begin
            Mem_Write = rst_n;
            Mem_Addr  = clr_cnt;
        end
`endif
    end

    // Read tag is one cycle behind the grant, matching the RAM's read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio      <= OWN_A;
            rd_issued <= 1'b0;
            rd_owner  <= OWN_A;
            a_hold    <= '0;
            b_hold    <= '0;
        end else begin
            if (gnt_a) begin
                prio <= OWN_B;
            end else if (gnt_b) begin
                prio <= OWN_A;
            end
            rd_issued <= (gnt_a && !bus.a_we) || (gnt_b && !bus.b_we);
            rd_owner  <= gnt_b ? OWN_B : OWN_A;
            if (a_rvalid) begin
                a_hold <= M_R_Data;
            end
            if (b_rvalid) begin
                b_hold <= M_R_Data;
            end
        end
    end

    // rst_n gating keeps a read issued just before reset from surfacing.
    always_comb begin
        a_rvalid     = rst_n && rd_issued && (rd_owner == OWN_A);
        b_rvalid     = rst_n && rd_issued && (rd_owner == OWN_B);
        bus.a_rvalid = a_rvalid;
        bus.b_rvalid = b_rvalid;
        bus.a_rdata  = !rst_n ? '0 : (a_rvalid ? M_R_Data : a_hold);
        bus.b_rdata  = !rst_n ? '0 : (b_rvalid ? M_R_Data : b_hold);
    end

endmodule

// File: tb/tb_ram_64x32_arbiter.sv
// Bench for ram_64x32_arbiter: behavioural RAM + reference model, directed and random stimulus.
module tb_ram_64x32_arbiter;

`ifdef RAM_ARB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        Mem_Write;
    logic [5:0]  Mem_Addr;
    logic [31:0] M_W_Data;
    logic [31:0] M_R_Data;

    int checks   = 0;
    int failures = 0;

    ram_64x32_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    ram_64x32_arbiter #(.ADDR_W(6), .DATA_W(32), .DEPTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .Mem_Write (Mem_Write),
        .Mem_Addr  (Mem_Addr),
        .M_W_Data  (M_W_Data),
        .M_R_Data  (M_R_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [5:0] a);
        return (32'h9E37_79B9 * (32'(a) + 32'd1)) ^ 32'h5A5A_0000;
    endfunction

    // Environment RAM: synchronous port, read data one cycle after the address.
    logic [31:0] ram [64];
    logic [63:0] ram_wr = '0;
    always @(posedge clk) begin
        M_R_Data <= ram_wr[Mem_Addr] ? ram[Mem_Addr] : init_val(Mem_Addr);
        if (Mem_Write) begin
            ram[Mem_Addr]    <= M_W_Data;
            ram_wr[Mem_Addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, advanced once per clock edge.
    bit          model_valid = 1'b0;
    bit          fav_b;
    bit          busy_m;
    int          clr_m;
    bit          pend_v;
    bit          pend_own;
    logic [31:0] pend_d;
    logic [31:0] a_hold_m;
    logic [31:0] b_hold_m;
    logic [31:0] mem_m [64];
    logic [63:0] mem_m_wr = '0;

    function automatic logic [31:0] model_rd(input logic [5:0] a);
        return mem_m_wr[a] ? mem_m[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        bit          r;
        bit          clearing;
        bit          eg_a;
        bit          eg_b;
        bit          e_arv;
        bit          e_brv;
        bit          e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wd;
        r        = rst_n;
        clearing = CLR && busy_m;
        eg_a     = r && !clearing && bus.a_req && (!bus.b_req || !fav_b);
        eg_b     = r && !clearing && bus.b_req && (!bus.a_req || fav_b);
        if (model_valid) begin
            e_arv = r && pend_v && !pend_own;
            e_brv = r && pend_v && pend_own;
            e_we = 1'b0; e_addr = '0; e_wd = '0;
            if (clearing) begin
                e_we = r; e_addr = 6'(clr_m);
            end else if (eg_a) begin
                e_we = bus.a_we; e_addr = bus.a_addr; e_wd = bus.a_wdata;
            end else if (eg_b) begin
                e_we = bus.b_we; e_addr = bus.b_addr; e_wd = bus.b_wdata;
            end
            chk("a_gnt", bus.a_gnt, eg_a);
            chk("b_gnt", bus.b_gnt, eg_b);
            chk("busy", busy, busy_m);
            chk("Mem_Write", Mem_Write, e_we);
            chk("Mem_Addr", Mem_Addr, e_addr);
            chk("M_W_Data", M_W_Data, e_wd);
            chk("a_rvalid", bus.a_rvalid, e_arv);
            chk("b_rvalid", bus.b_rvalid, e_brv);
            chk("a_rdata", bus.a_rdata, !r ? 32'd0 : (e_arv ? pend_d : a_hold_m));
            chk("b_rdata", bus.b_rdata, !r ? 32'd0 : (e_brv ? pend_d : b_hold_m));
        end
        if (!r) begin
            model_valid = 1'b1;
            fav_b = 1'b0; pend_v = 1'b0; a_hold_m = '0; b_hold_m = '0;
            clr_m = 0; busy_m = CLR;
        end else if (model_valid) begin
            if (pend_v) begin
                if (pend_own) b_hold_m = pend_d;
                else          a_hold_m = pend_d;
            end
            pend_v = 1'b0;
            if (clearing) begin
                mem_m[clr_m] = '0;
                mem_m_wr[clr_m] = 1'b1;
                if (clr_m == 63) busy_m = 1'b0;
                clr_m++;
            end else if (eg_a || eg_b) begin
                pend_own = eg_b;
                pend_v   = eg_b ? !bus.b_we : !bus.a_we;
                pend_d   = model_rd(eg_b ? bus.b_addr : bus.a_addr);
                if (eg_b ? bus.b_we : bus.a_we) begin
                    mem_m[eg_b ? bus.b_addr : bus.a_addr]    = eg_b ? bus.b_wdata : bus.a_wdata;
                    mem_m_wr[eg_b ? bus.b_addr : bus.a_addr] = 1'b1;
                end
                fav_b = eg_a;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one access and hold it until granted; returns just after the commit edge.
    task automatic access(input bit use_b, input bit we, input logic [5:0] addr, input logic [31:0] d);
        bit got = 1'b0;
        cyc();
        if (use_b) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (use_b ? bus.b_gnt : bus.a_gnt) begin
                got = 1'b1;
                break;
            end
        end
        chk("access_grant_seen", 32'(got), 32'd1);
        cyc();
        if (use_b) bus.b_req = 1'b0;
        else       bus.a_req = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk(name, 32'(n), CLR ? 32'd64 : 32'd0);
    endtask

    initial begin
        int          n;
        bit          ag;
        bit          bg;
        logic [5:0]  gb;
        logic [5:0]  ga;
        logic [5:0]  rvb;
        logic [5:0]  rva;

        rst_n = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 6'd0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 6'd0; bus.b_wdata = '0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_busy", busy, CLR);
        chk("rst_a_gnt_forced", bus.a_gnt, 1'b0);
        chk("rst_a_rdata", bus.a_rdata, 32'd0);
        chk("rst_mem_write", Mem_Write, 1'b0);

        // Reset release with A already requesting a read of address 0.
        cyc();
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.a_gnt) begin
                n = k;
                break;
            end
        end
        chk("first_gnt_cycle", 32'(n), CLR ? 32'd65 : 32'd1);
        cyc();
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("rd0_rvalid", bus.a_rvalid, 1'b1);
        if (CLR) begin
            chk("rd0_cleared", bus.a_rdata, 32'd0);
            access(1'b0, 1'b0, 6'd31, '0);
            @(negedge clk);
            chk("rd31_cleared", bus.a_rdata, 32'd0);
            access(1'b0, 1'b0, 6'd63, '0);
            @(negedge clk);
            chk("rd63_cleared", bus.a_rdata, 32'd0);
        end

        access(1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF);
        access(1'b0, 1'b0, 6'd5, '0);
        @(negedge clk);
        chk("a_rd5_rvalid", bus.a_rvalid, 1'b1);
        chk("a_rd5_data", bus.a_rdata, 32'hDEAD_BEEF);
        chk("a_rd5_b_rvalid", bus.b_rvalid, 1'b0);

        access(1'b1, 1'b1, 6'd63, 32'h1234_5678);
        access(1'b1, 1'b0, 6'd63, '0);
        @(negedge clk);
        chk("b_rd63_rvalid", bus.b_rvalid, 1'b1);
        chk("b_rd63_data", bus.b_rdata, 32'h1234_5678);

        // Continuous contention after a B grant: A must win first, then strict alternation.
        cyc();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 6'd1;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 6'd2;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) begin
                ga[i] = bus.a_gnt;
                gb[i] = bus.b_gnt;
            end
            if (i >= 1) begin
                rva[i-1] = bus.a_rvalid;
                rvb[i-1] = bus.b_rvalid;
            end
            if (i == 5) begin
                cyc();
                bus.a_req = 1'b0;
                bus.b_req = 1'b0;
            end
        end
        chk("alt_gnt_a", 32'(ga), 32'b010101);
        chk("alt_gnt_b", 32'(gb), 32'b101010);
        chk("alt_rvalid_a", 32'(rva), 32'b010101);
        chk("alt_rvalid_b", 32'(rvb), 32'b101010);

        // Read granted, reset asserted in the following cycle.
        access(1'b0, 1'b0, 6'd5, '0);
        rst_n = 1'b0;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 6'd9;
        @(negedge clk);
        chk("rd_before_rst_rvalid", bus.a_rvalid, 1'b0);
        chk("rst_b_gnt_forced", bus.b_gnt, 1'b0);
        cyc();
        @(negedge clk);
        chk("rst2_a_rdata", bus.a_rdata, 32'd0);
        chk("rst2_b_rdata", bus.b_rdata, 32'd0);
        chk("rst2_busy", busy, CLR);
        cyc();
        bus.b_req = 1'b0;
        rst_n = 1'b1;
        if (CLR) begin
            n = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (busy && Mem_Addr == 6'd30) begin
                    n = 1;
                    break;
                end
            end
            chk("clr_reached_30", 32'(n), 32'd1);
            cyc();
            rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
        end
        count_busy("clear_len_after_restart");

        // Randomized traffic with occasional resets, checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            ag = bus.a_gnt;
            bg = bus.b_gnt;
            cyc();
            if (!bus.a_req || ag) begin
                bus.a_req   = ($urandom_range(0, 3) != 0);
                bus.a_we    = 1'($urandom_range(0, 1));
                bus.a_addr  = 6'($urandom_range(0, 63));
                bus.a_wdata = $urandom;
            end
            if (!bus.b_req || bg) begin
                bus.b_req   = ($urandom_range(0, 2) != 0);
                bus.b_we    = 1'($urandom_range(0, 1));
                bus.b_addr  = 6'($urandom_range(0, 63));
                bus.b_wdata = $urandom;
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        end
        cyc();
        rst_n = 1'b1;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
